multicycle_alu_unit: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU for the multicycle core. Adds a start/done handshake, 4-bit opcodes with signed compare, XOR and arithmetic shift right, plus iterative unsigned multiply and divide producing a double-width result. Sits in the execute stage; the control FSM issues `start` and waits on `done`.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/mul_div_iter.sv | 77 +++++++
 rtl/multicycle_alu_unit.sv | 162 ++++++++++++++++
 tb/tb_multicycle_alu_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle execute-stage ALU: opcode encodings,
// FSM states and the helper that routes an opcode to the iterative datapath.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_MULU = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Divide-by-zero is still reported here; the top short-cuts it separately.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SUB,
      ALU_SLTU, ALU_XOR, ALU_MULU, ALU_DIVU, ALU_SRA, ALU_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Shared WIDTH-step datapath: shift-add unsigned multiply or restoring unsigned
// divide, one bit per step. next_hi/next_lo expose the value after the current step.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] op_b_q;
  logic             mode_q;
  logic [SHW-1:0]   count;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Multiply: acc_lo holds the multiplier, consumed LSB first while product
  // bits shift in from the top. Divide: acc_lo holds the dividend, consumed
  // MSB first while quotient bits shift in from the bottom; acc_hi is the remainder.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b_q} : {(WIDTH+1){1'b0}});
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_b_q};
    if (trial[WIDTH]) begin
      div_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      div_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      div_hi = trial[WIDTH-1:0];
      div_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end

    next_hi = mode_q ? div_hi : mul_hi;
    next_lo = mode_q ? div_lo : mul_lo;
    last    = (count == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      op_b_q <= '0;
      mode_q <= 1'b0;
      count  <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= op_a;
      op_b_q <= op_b;
      mode_q <= div_mode;
      count  <= SHW'(WIDTH - 1);
    end else if (step) begin
      acc_hi <= next_hi;
      acc_lo <= next_lo;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_alu_unit.sv
// Registered execute-stage ALU with start/done handshake. Logic, shift, add/sub and
// compare finish in one cycle; MULU and DIVU run WIDTH steps in mul_div_iter.
module multicycle_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUoperations,
  input  logic [WIDTH-1:0] operend1,
  input  logic [WIDTH-1:0] operend2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] resultOut,
  output logic [WIDTH-1:0] resultHi,
  output logic             carryOut,
  output logic             overflow,
  output logic             isZero,
  output logic             illegalOp
);

  localparam int SHW = $clog2(WIDTH);

  state_t state;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             long_op;
  logic             iter_load;
  logic             iter_step;
  logic             iter_last;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  logic [WIDTH-1:0] c_lo;
  logic [WIDTH-1:0] c_hi;
  logic             c_carry;
  logic             c_ovf;
  logic             c_illegal;

  assign shamt     = operend1[SHW-1:0];
  assign add_full  = {1'b0, operend1} + {1'b0, operend2};
  assign sub_full  = {1'b0, operend1} - {1'b0, operend2};
  // A zero divisor never enters the iterative path; it completes like a single-cycle op.
  assign long_op   = is_multicycle(ALUoperations) &&
                     !((ALUoperations == ALU_DIVU) && (operend2 == '0));
  assign iter_load = start && ready && long_op;
  assign iter_step = (state == ITER);

  always_comb begin
    c_lo      = '0;
    c_hi      = '0;
    c_carry   = 1'b0;
    c_ovf     = 1'b0;
    c_illegal = !is_defined(ALUoperations);
    case (ALUoperations)
      ALU_AND:  c_lo = operend1 & operend2;
      ALU_OR:   c_lo = operend1 | operend2;
      ALU_XOR:  c_lo = operend1 ^ operend2;
      ALU_NOR:  c_lo = ~(operend1 | operend2);
      ALU_ADD: begin
        c_lo    = add_full[WIDTH-1:0];
        c_carry = add_full[WIDTH];
        c_ovf   = (operend1[WIDTH-1] == operend2[WIDTH-1]) &&
                  (add_full[WIDTH-1] != operend1[WIDTH-1]);
      end
      // The borrow out of the widened subtraction is exactly operend1 < operend2.
      ALU_SUB: begin
        c_lo    = sub_full[WIDTH-1:0];
        c_carry = sub_full[WIDTH];
        c_ovf   = (operend1[WIDTH-1] != operend2[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != operend1[WIDTH-1]);
      end
      ALU_SLL:  c_lo = operend2 << shamt;
      ALU_SRL:  c_lo = operend2 >> shamt;
      ALU_SRA:  c_lo = WIDTH'($signed(operend2) >>> shamt);
      ALU_SLTU: c_lo = {{(WIDTH-1){1'b0}}, (operend1 < operend2)};
      ALU_SLT:  c_lo = {{(WIDTH-1){1'b0}}, ($signed(operend1) < $signed(operend2))};
      ALU_DIVU: begin
        if (operend2 == '0) begin
          c_lo = '1;
          c_hi = operend1;
        end
      end
      default: c_lo = '0;
    endcase
  end

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_mul_div_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
    .step    (iter_step),
    .div_mode(ALUoperations == ALU_DIVU),
    .op_a    (operend1),
    .op_b    (operend2),
    .last    (iter_last),
    .next_hi (iter_hi),
    .next_lo (iter_lo)
  );

  // Results are captured on the edge that enters FIN so done and data appear
  // together; FIN already accepts new work, allowing issue on the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      resultOut <= '0;
      resultHi  <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
      isZero    <= 1'b1;
      illegalOp <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          if (start && ready) begin
            if (long_op) begin
              state <= ITER;
              ready <= 1'b0;
            end else begin
              done      <= 1'b1;
              resultOut <= c_lo;
              resultHi  <= c_hi;
              carryOut  <= c_carry;
              overflow  <= c_ovf;
              isZero    <= (c_lo == '0);
              illegalOp <= c_illegal;
            end
          end
        end
        ITER: begin
          if (iter_last) begin
            state     <= FIN;
            ready     <= 1'b1;
            done      <= 1'b1;
            resultOut <= iter_lo;
            resultHi  <= iter_hi;
            carryOut  <= 1'b0;
            overflow  <= 1'b0;
            isZero    <= (iter_lo == '0);
            illegalOp <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu_unit.sv
// Scoreboard bench for multicycle_alu_unit: stimulus pushes reference-model results,
// an independent monitor pops them on every done pulse and checks timing and data.
module tb_multicycle_alu_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         illegal;
    logic [3:0]   op;
    longint       cyc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   ALUoperations;
  logic [W-1:0] operend1;
  logic [W-1:0] operend2;
  logic         ready;
  logic         done;
  logic [W-1:0] resultOut;
  logic [W-1:0] resultHi;
  logic         carryOut;
  logic         overflow;
  logic         isZero;
  logic         illegalOp;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint cyc;
  longint busy_until;
  int     tests_run;
  int     tests_failed;

  multicycle_alu_unit #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUoperations(ALUoperations),
    .operend1     (operend1),
    .operend2     (operend2),
    .ready        (ready),
    .done         (done),
    .resultOut    (resultOut),
    .resultHi     (resultHi),
    .carryOut     (carryOut),
    .overflow     (overflow),
    .isZero       (isZero),
    .illegalOp    (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Reference: plain arithmetic on the mathematical definition of each opcode.
  function automatic exp_t refModel(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      r;
    logic [63:0] p;
    e.lo = '0; e.hi = '0; e.carry = 1'b0; e.ovf = 1'b0; e.illegal = 1'b0;
    e.op = op; e.cyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0011: e.lo = ~(a | b);
      4'b1000: e.lo = a ^ b;
      4'b0010: begin
        p = {32'd0, a} + {32'd0, b};
        e.lo = p[31:0];
        e.carry = p[32];
        r = sa + sb;
        e.ovf = (r != longint'($signed(e.lo)));
      end
      4'b0110: begin
        e.lo = a - b;
        e.carry = (a < b);
        r = sa - sb;
        e.ovf = (r != longint'($signed(e.lo)));
      end
      4'b0100: e.lo = b << a[4:0];
      4'b0101: e.lo = b >> a[4:0];
      4'b1101: e.lo = 32'($signed(b) >>> a[4:0]);
      4'b0111: e.lo = (a < b) ? 32'd1 : 32'd0;
      4'b1111: e.lo = (sa < sb) ? 32'd1 : 32'd0;
      4'b1010: begin
        p = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      4'b1011: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.lo == 0);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'b1010 || (op == 4'b1011 && b != 0)) return W + 1;
    return 1;
  endfunction

  // Issues one op on the first cycle the model says the unit is free.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    exp_t e;
    int   lat;
    @(negedge clk); #1;
    while (cyc < busy_until) begin
      start = 1'b0;
      @(negedge clk); #1;
    end
    start = 1'b1;
    ALUoperations = op;
    operend1 = a;
    operend2 = b;
    lat = latency(op, b);
    e = refModel(op, a, b);
    e.cyc = cyc + lat;
    if (lat > 1) busy_until = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      start = 1'b0;
      ALUoperations = 4'($urandom);
      operend1 = $urandom;
      operend2 = $urandom;
    end
  endtask

  // Drives start while the unit is busy; no response is expected.
  task automatic pokeBusy();
    @(negedge clk); #1;
    if (cyc < busy_until) begin
      start = 1'b1;
      ALUoperations = 4'b0010;
      operend1 = $urandom;
      operend2 = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"}, ready, 1);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_resultOut"}, resultOut, 0);
    checkOutput({tag, "_resultHi"}, resultHi, 0);
    checkOutput({tag, "_carryOut"}, carryOut, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_illegalOp"}, illegalOp, 0);
    checkOutput({tag, "_isZero"}, isZero, 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ready", ready, (cyc >= busy_until));
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        checkOutput($sformatf("done_op%b", mon_e.op), done, 1);
        if (done) begin
          checkOutput($sformatf("resultOut_op%b", mon_e.op), resultOut, mon_e.lo);
          checkOutput($sformatf("resultHi_op%b", mon_e.op), resultHi, mon_e.hi);
          checkOutput($sformatf("carryOut_op%b", mon_e.op), carryOut, mon_e.carry);
          checkOutput($sformatf("overflow_op%b", mon_e.op), overflow, mon_e.ovf);
          checkOutput($sformatf("isZero_op%b", mon_e.op), isZero, mon_e.zero);
          checkOutput($sformatf("illegalOp_op%b", mon_e.op), illegalOp, mon_e.illegal);
        end
      end else begin
        checkOutput("unexpected_done", done, 0);
      end
    end
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    tests_run = 0;
    tests_failed = 0;
    busy_until = 0;
    reset = 1'b1;
    start = 1'b0;
    ALUoperations = '0;
    operend1 = '0;
    operend2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkReset("por");
    reset = 1'b0;

    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(4'b0110, 32'h8000_0000, 32'h1);
    applyStimulus(4'b1111, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(4'b1101, 32'h21, 32'h8000_0000);
    applyStimulus(4'b0100, 32'h20, 32'h1234_5678);
    applyStimulus(4'b0101, 32'hFFFF_FFE4, 32'hF000_000F);
    applyStimulus(4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    applyStimulus(4'b0011, 32'h0F0F_0000, 32'h0000_F0F0);
    applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1);
    applyStimulus(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pokeBusy();
    pokeBusy();
    idleCycles(3);
    pokeBusy();
    applyStimulus(4'b1011, 32'd100, 32'd7);
    applyStimulus(4'b1011, 32'd5, 32'd0);
    applyStimulus(4'b1110, 32'h1234, 32'h5678);
    applyStimulus(4'b1010, 32'd0, 32'h1234_5678);
    applyStimulus(4'b1011, 32'd3, 32'hFFFF_FFFF);
    idleCycles(2);

    applyStimulus(4'b1010, 32'hDEAD_BEEF, 32'h1234_5678);
    idleCycles(5);
    @(negedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    exp_q.delete();
    busy_until = 0;
    @(negedge clk); #1;
    checkReset("mid_iter");
    reset = 1'b0;

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(0, 9)); end
        2: begin a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                 b = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h0; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      applyStimulus(op, a, b);
      if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 3));
    end

    idleCycles(2);
    while (cyc <= busy_until + 2) idleCycles(1);
    idleCycles(2);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
